// File: rtl/mult_accumulator.sv
// Burst accumulator behind the 4x4 array multiplier: sums a burst of 8-bit products
// into an ACC_W-bit register and emits one {sum, count, overflow} result per burst.
module mult_accumulator #(
  parameter int ACC_W   = 10,
  parameter int MAX_LEN = 4,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] res_sum_q, res_sum_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
  logic             res_ovf_q, res_ovf_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic             closing;
  logic [ACC_W:0]   sum_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             ovf_next;

  // A held result only blocks input while downstream is not taking it this cycle.
  assign in_ready = !rst && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  assign sum_next = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, in_prod};
  assign ovf_next = ovf_q | sum_next[ACC_W];
  assign cnt_inc  = cnt_q + 1'b1;
  assign closing  = in_last || (cnt_inc == CNT_W'(MAX_LEN));

  always_comb begin
    // NOTE: every next-state signal is defaulted to its current value first, so no
    // path through the branches below can leave one unassigned and infer a latch.
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    res_sum_d   = res_sum_q;
    res_cnt_d   = res_cnt_q;
    res_ovf_d   = res_ovf_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (closing) begin
        // A closing beat overrides the take above, so a fresh result can replace
        // the one leaving in the same cycle without a bubble.
        res_sum_d   = sum_next[ACC_W-1:0];
        res_cnt_d   = cnt_inc;
        res_ovf_d   = ovf_next;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
      end else begin
        acc_d = sum_next[ACC_W-1:0];
        cnt_d = cnt_inc;
        ovf_d = ovf_next;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register samples
  // the pre-edge values computed above; all of them, result side included, reset
  // to zero so a reset discards both the partial burst and any held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      res_sum_q   <= '0;
      res_cnt_q   <= '0;
      res_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      res_sum_q   <= res_sum_d;
      res_cnt_q   <= res_cnt_d;
      res_ovf_q   <= res_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = res_sum_q;
  assign out_count = res_cnt_q;
  assign out_ovf   = res_ovf_q;

endmodule

// File: tb/tb_mult_accumulator.sv
// Self-checking bench for mult_accumulator: directed scenarios plus randomized traffic
// compared against a burst-level reference model (plain sums over each burst).
module tb_mult_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_prod;
  logic       in_last;
  logic       out_ready;

  logic       rdy4, val4, ovf4;
  logic [9:0] sum4;
  logic [2:0] cnt4;
  logic       rdy8, val8, ovf8;
  logic [9:0] sum8;
  logic [3:0] cnt8;

  int sel;
  logic       m_ready, m_valid, m_ovf;
  logic [9:0] m_sum;
  logic [3:0] m_cnt;

  logic       s_valid, s_ovf;
  logic [9:0] s_sum;
  logic [3:0] s_cnt;
  int         s_waits;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int sum;
    int cnt;
    bit ovf;
  } res_t;

  always #5 clk = ~clk;

  // Default-parameter instance (ACC_W=10, MAX_LEN=4)
  mult_accumulator dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .in_prod(in_prod),
    .in_last(in_last), .out_valid(val4), .out_ready(out_ready), .out_sum(sum4),
    .out_count(cnt4), .out_ovf(ovf4)
  );

  // Longer-burst instance used for the overflow scenario
  mult_accumulator #(.ACC_W(10), .MAX_LEN(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8), .in_prod(in_prod),
    .in_last(in_last), .out_valid(val8), .out_ready(out_ready), .out_sum(sum8),
    .out_count(cnt8), .out_ovf(ovf8)
  );

  always_comb begin
    if (sel == 8) begin
      m_ready = rdy8; m_valid = val8; m_sum = sum8; m_cnt = cnt8; m_ovf = ovf8;
    end else begin
      m_ready = rdy4; m_valid = val4; m_sum = sum4; m_cnt = {1'b0, cnt4}; m_ovf = ovf4;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_prod = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Offers one beat, holding it until accepted (bounded); snapshots outputs at the accept cycle.
  task automatic send_beat(input logic [7:0] p, input logic l);
    bit got = 0;
    in_valid = 1'b1; in_prod = p; in_last = l;
    s_waits = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      s_valid = m_valid; s_sum = m_sum; s_cnt = m_cnt; s_ovf = m_ovf;
      got = m_ready;
      s_waits++;
      @(posedge clk); #1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL beat_timeout: prod=%0d not accepted within 20 cycles", p);
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic test_reset();
    sel = 4;
    rst = 1'b1; in_valid = 1'b1; in_prod = 8'd200; in_last = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({m_ready, m_valid, m_sum, m_cnt, m_ovf} !== 17'd0) begin
        errors++;
        $display("FAIL reset_state: got rdy=%0d v=%0d sum=%0d cnt=%0d ovf=%0d, want all 0",
                 m_ready, m_valid, m_sum, m_cnt, m_ovf);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({m_ready, m_valid} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release: got rdy=%0d v=%0d, want rdy=1 v=0", m_ready, m_valid);
    end
    @(posedge clk); #1;
    send_beat(8'd5, 1'b1);
    @(negedge clk);
    checks++;
    if ({m_valid, m_sum, m_cnt, m_ovf} !== {1'b1, 10'd5, 4'd1, 1'b0}) begin
      errors++;
      $display("FAIL reset_acc_clear: got v=%0d sum=%0d cnt=%0d ovf=%0d, want v=1 sum=5 cnt=1 ovf=0",
               m_valid, m_sum, m_cnt, m_ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    sel = 4; do_reset(); out_ready = 1'b1;
    send_beat(8'd6, 1'b0); send_beat(8'd12, 1'b0); send_beat(8'd20, 1'b0); send_beat(8'd30, 1'b1);
    @(negedge clk);
    checks++;
    if ({m_valid, m_sum, m_cnt, m_ovf} !== {1'b1, 10'd68, 4'd4, 1'b0}) begin
      errors++;
      $display("FAIL basic_result: got v=%0d sum=%0d cnt=%0d ovf=%0d, want v=1 sum=68 cnt=4 ovf=0",
               m_valid, m_sum, m_cnt, m_ovf);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_drop: got out_valid=%0d, want 0", m_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_force_close();
    sel = 4; do_reset(); out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_beat(8'd1, 1'b0);
    checks++;
    if ({s_valid, s_sum, s_cnt, s_ovf} !== {1'b1, 10'd4, 4'd4, 1'b0}) begin
      errors++;
      $display("FAIL force_close_first: got v=%0d sum=%0d cnt=%0d ovf=%0d, want v=1 sum=4 cnt=4 ovf=0",
               s_valid, s_sum, s_cnt, s_ovf);
    end
    send_beat(8'd3, 1'b1);
    checks++;
    if (s_valid !== 1'b0) begin
      errors++;
      $display("FAIL force_close_gap: got out_valid=%0d, want 0", s_valid);
    end
    @(negedge clk);
    checks++;
    if ({m_valid, m_sum, m_cnt, m_ovf} !== {1'b1, 10'd4, 4'd2, 1'b0}) begin
      errors++;
      $display("FAIL force_close_second: got v=%0d sum=%0d cnt=%0d ovf=%0d, want v=1 sum=4 cnt=2 ovf=0",
               m_valid, m_sum, m_cnt, m_ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    sel = 8; do_reset(); out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_beat(8'd225, (i == 4));
    @(negedge clk);
    checks++;
    if ({m_valid, m_sum, m_cnt, m_ovf} !== {1'b1, 10'd101, 4'd5, 1'b1}) begin
      errors++;
      $display("FAIL overflow_result: got v=%0d sum=%0d cnt=%0d ovf=%0d, want v=1 sum=101 cnt=5 ovf=1",
               m_valid, m_sum, m_cnt, m_ovf);
    end
    @(posedge clk); #1;
    send_beat(8'd7, 1'b1);
    @(negedge clk);
    checks++;
    if ({m_valid, m_sum, m_cnt, m_ovf} !== {1'b1, 10'd7, 4'd1, 1'b0}) begin
      errors++;
      $display("FAIL overflow_cleared: got v=%0d sum=%0d cnt=%0d ovf=%0d, want v=1 sum=7 cnt=1 ovf=0",
               m_valid, m_sum, m_cnt, m_ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    sel = 4; do_reset(); out_ready = 1'b0;
    send_beat(8'd6, 1'b0); send_beat(8'd12, 1'b0); send_beat(8'd20, 1'b0); send_beat(8'd30, 1'b1);
    in_valid = 1'b1; in_prod = 8'd9; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({m_ready, m_valid, m_sum, m_cnt, m_ovf} !== {1'b0, 1'b1, 10'd68, 4'd4, 1'b0}) begin
        errors++;
        $display("FAIL backpressure_hold: got rdy=%0d v=%0d sum=%0d cnt=%0d ovf=%0d, want rdy=0 v=1 sum=68 cnt=4 ovf=0",
                 m_ready, m_valid, m_sum, m_cnt, m_ovf);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (m_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: got in_ready=%0d, want 1", m_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    checks++;
    if ({m_valid, m_sum, m_cnt, m_ovf} !== {1'b1, 10'd9, 4'd1, 1'b0}) begin
      errors++;
      $display("FAIL simultaneous_replace: got v=%0d sum=%0d cnt=%0d ovf=%0d, want v=1 sum=9 cnt=1 ovf=0",
               m_valid, m_sum, m_cnt, m_ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_burst();
    sel = 4; do_reset(); out_ready = 1'b1;
    send_beat(8'd50, 1'b0); send_beat(8'd60, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({m_ready, m_valid} !== 2'b00) begin
      errors++;
      $display("FAIL midreset_during: got rdy=%0d v=%0d, want rdy=0 v=0", m_ready, m_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    send_beat(8'd17, 1'b1);
    checks++;
    if (s_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_discard: got out_valid=%0d sum=%0d, want no result", s_valid, s_sum);
    end
    @(negedge clk);
    checks++;
    if ({m_valid, m_sum, m_cnt, m_ovf} !== {1'b1, 10'd17, 4'd1, 1'b0}) begin
      errors++;
      $display("FAIL midreset_result: got v=%0d sum=%0d cnt=%0d ovf=%0d, want v=1 sum=17 cnt=1 ovf=0",
               m_valid, m_sum, m_cnt, m_ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    sel = 4; do_reset(); out_ready = 1'b1;
    send_beat(8'd10, 1'b1);
    send_beat(8'd20, 1'b1);
    checks++;
    if ({s_valid, s_sum, s_cnt, s_waits[3:0]} !== {1'b1, 10'd10, 4'd1, 4'd1}) begin
      errors++;
      $display("FAIL b2b_first: got v=%0d sum=%0d cnt=%0d waits=%0d, want v=1 sum=10 cnt=1 waits=1",
               s_valid, s_sum, s_cnt, s_waits);
    end
    send_beat(8'd30, 1'b0);
    checks++;
    if ({s_valid, s_sum, s_cnt, s_waits[3:0]} !== {1'b1, 10'd20, 4'd1, 4'd1}) begin
      errors++;
      $display("FAIL b2b_second: got v=%0d sum=%0d cnt=%0d waits=%0d, want v=1 sum=20 cnt=1 waits=1",
               s_valid, s_sum, s_cnt, s_waits);
    end
    send_beat(8'd40, 1'b1);
    @(negedge clk);
    checks++;
    if ({m_valid, m_sum, m_cnt, m_ovf} !== {1'b1, 10'd70, 4'd2, 1'b0}) begin
      errors++;
      $display("FAIL b2b_third: got v=%0d sum=%0d cnt=%0d ovf=%0d, want v=1 sum=70 cnt=2 ovf=0",
               m_valid, m_sum, m_cnt, m_ovf);
    end
    @(posedge clk); #1;
  endtask

  // Reference: a burst's result is its plain integer total mod 1024; overflow iff total >= 1024.
  task automatic test_random(input int which, input int n);
    res_t q[$];
    res_t r;
    int   bsum = 0;
    int   bcnt = 0;
    int   mlen = (which == 8) ? 8 : 4;
    bit   pending = 0;
    bit   exp_ready, accepted;
    sel = which; do_reset();
    for (int c = 0; c < n; c++) begin
      if (!pending) begin
        in_valid = ($urandom % 4) != 0;
        in_prod  = 8'($urandom);
        in_last  = ($urandom % 3) == 0;
      end
      out_ready = ($urandom % 3) != 0;
      @(negedge clk);
      exp_ready = (q.size() == 0) || out_ready;
      checks++;
      if ({m_ready, m_valid} !== {exp_ready, q.size() != 0}) begin
        errors++;
        $display("FAIL rand_handshake cyc %0d: got rdy=%0d v=%0d, want rdy=%0d v=%0d",
                 c, m_ready, m_valid, exp_ready, q.size() != 0);
      end
      if (q.size() != 0) begin
        checks++;
        if (m_sum !== 10'(q[0].sum) || m_cnt !== 4'(q[0].cnt) || m_ovf !== q[0].ovf) begin
          errors++;
          $display("FAIL rand_result cyc %0d: got sum=%0d cnt=%0d ovf=%0d, want sum=%0d cnt=%0d ovf=%0d",
                   c, m_sum, m_cnt, m_ovf, q[0].sum, q[0].cnt, q[0].ovf);
        end
        if (out_ready) void'(q.pop_front());
      end
      accepted = in_valid && exp_ready;
      if (accepted) begin
        bsum += int'(in_prod);
        bcnt++;
        if (in_last || bcnt == mlen) begin
          r.sum = bsum % 1024; r.cnt = bcnt; r.ovf = (bsum >= 1024);
          q.push_back(r);
          bsum = 0; bcnt = 0;
        end
      end
      pending = in_valid && !accepted;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  initial begin
    sel = 4; rst = 1'b1; in_valid = 1'b0; in_prod = '0; in_last = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_force_close();
    test_overflow();
    test_backpressure();
    test_reset_mid_burst();
    test_back_to_back();
    test_random(4, 400);
    test_random(8, 400);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
